// File: rtl/sb_pkg.sv
// Shared definitions for the register write scoreboard.
// The decoder also uses the LAT_* constants to drive issue_lat.
package sb_pkg;

  localparam int NREG = 8;
  localparam int AW   = 3;
  localparam int LATW = 3;

  typedef logic [LATW-1:0] lat_t;
  typedef logic [AW-1:0]   reg_idx_t;

  // Producer latencies: cycles until a result can be forwarded.
  localparam lat_t LAT_ALU  = 3'd0;
  localparam lat_t LAT_LOAD = 3'd1;
  localparam lat_t LAT_MUL  = 3'd4;

  // Operation a single counter performs on the next edge.
  typedef enum logic [1:0] {
    CNT_HOLD  = 2'd0,
    CNT_DEC   = 2'd1,
    CNT_CLEAR = 2'd2,
    CNT_SET   = 2'd3
  } cnt_op_e;

  // A register is pending while its counter is non-zero.
  function automatic logic is_pending(input lat_t c);
    return c != '0;
  endfunction

endpackage

// File: rtl/sb_entry.sv
// One scoreboard counter: a new record overrides an early writeback,
// which overrides the normal per-cycle countdown.
module sb_entry
  import sb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  lat_t set_val,
  input  logic clr,
  output lat_t cnt,
  output lat_t cnt_next
);

  lat_t    cnt_q;
  lat_t    cnt_d;
  cnt_op_e op;

  // Choose this cycle's counter operation in priority order.
  always_comb begin
    op = CNT_HOLD;
    if (set) begin
      op = CNT_SET;
    end else if (clr && is_pending(cnt_q)) begin
      op = CNT_CLEAR;
    end else if (is_pending(cnt_q)) begin
      op = CNT_DEC;
    end
  end

  // Compute the next counter value from the chosen operation.
  always_comb begin
    cnt_d = cnt_q;
    unique case (op)
      CNT_SET:   cnt_d = set_val;
      CNT_CLEAR: cnt_d = '0;
      CNT_DEC:   cnt_d = cnt_q - 1'b1;
      CNT_HOLD:  cnt_d = cnt_q;
    endcase
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt      = cnt_q;
  assign cnt_next = cnt_d;

endmodule

// File: rtl/reg_scoreboard.sv
// Writer-side hazard tracker: one countdown per architectural register,
// a combinational stall for RAW/WAW hazards against the ID instruction,
// and registered busy/idle status.
module reg_scoreboard
  import sb_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic            issue_wr,
  input  logic [AW-1:0]   issue_rd,
  input  logic [LATW-1:0] issue_lat,
  input  logic            flush,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic            use_rs1,
  input  logic            use_rs2,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  output logic            stall,
  output logic [NREG-1:0] busy,
  output logic            idle
);

  lat_t            cnt      [NREG];
  lat_t            cnt_next [NREG];
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;
  logic            raw;
  logic            waw;
  logic            accept;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] busy_q;
  logic            idle_d;
  logic            idle_q;

  // Hazard detection and the decision to record the ID instruction's write.
  always_comb begin
    raw    = (use_rs1 && is_pending(cnt[rs1])) ||
             (use_rs2 && is_pending(cnt[rs2]));
    waw    = issue_valid && issue_wr && (cnt[issue_rd] > issue_lat);
    stall  = issue_valid && !flush && (raw || waw);
    accept = issue_valid && !flush && !stall && issue_wr && (issue_lat != '0);
  end

  // Decode the record and early-writeback targets into one-hot strobes.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (accept) begin
      set_vec[issue_rd] = 1'b1;
    end
    if (wb_valid) begin
      clr_vec[wb_rd] = 1'b1;
    end
  end

  for (genvar i = 0; i < NREG; i++) begin : g_entry
    sb_entry u_entry (
      .clk      (clk),
      .rst      (rst),
      .set      (set_vec[i]),
      .set_val  (issue_lat),
      .clr      (clr_vec[i]),
      .cnt      (cnt[i]),
      .cnt_next (cnt_next[i])
    );
  end

  // Status follows the counters' next values so it lines up with them.
  always_comb begin
    busy_d = '0;
    for (int i = 0; i < NREG; i++) begin
      busy_d[i] = is_pending(cnt_next[i]);
    end
    idle_d = (busy_d == '0);
  end

  // Busy/idle status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      idle_q <= 1'b1;
    end else begin
      busy_q <= busy_d;
      idle_q <= idle_d;
    end
  end

  assign busy = busy_q;
  assign idle = idle_q;

endmodule
